// File: rtl/readout_pkg.sv
// Shared definitions for the readout chain controller: state encoding,
// header tag, counter widths and a saturating increment helper.
package readout_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    START,
    WAIT_TX,
    RECEIVE,
    NEXT,
    DONE
  } state_e;

  localparam logic [3:0] HDR_TAG    = 4'hC;
  localparam int         WORD_CNT_W = 16;
  localparam int         TMR_W      = 16;

  // Word counter increment that sticks at all-ones instead of wrapping
  function automatic logic [WORD_CNT_W-1:0] satInc(input logic [WORD_CNT_W-1:0] v);
    return (v == {WORD_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/readout_gap_timer.sv
// Generic clear/count/expire counter. Expire_o is asserted on the counting
// cycle in which Limit_i counts have been seen; the counter then restarts at 0.
module readout_gap_timer #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Rst_N,
  input  logic         Clear_i,
  input  logic         Count_i,
  input  logic [W-1:0] Limit_i,
  output logic         Expire_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q;

  assign Expire_o = Count_i && (cnt_q == (Limit_i - ONE));

  // Count qualifying cycles, restarting on clear or when the limit is hit
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      cnt_q <= '0;
    end else if (Clear_i || Expire_o) begin
      cnt_q <= '0;
    end else if (Count_i) begin
      cnt_q <= cnt_q + ONE;
    end
  end

endmodule

// File: rtl/readout_chain_ctrl.sv
// Daisy-chain readout sequencer: walks the enabled chips one at a time,
// pulses StartReadout, waits for TransmitOnb, counts words and detects the
// end-of-chip gap. Optional packet header output enabled by CHIP_HEADER_EN.
module readout_chain_ctrl
  import readout_pkg::*;
#(
  parameter int N_CHIP     = 4,
  parameter int START_LEN  = 4,
  parameter int TX_TIMEOUT = 4096,
  parameter int END_GAP    = 8
) (
  input  logic              Clk,
  input  logic              Rst_N,
  input  logic              In_Start,
  input  logic [N_CHIP-1:0] In_Chip_Mask,
  input  logic              In_TransmitOnb,
  input  logic              In_Word_En,
  input  logic [11:0]       In_Num_Receive,
  output logic [N_CHIP-1:0] Out_StartReadout,
  output logic [3:0]        Out_Chip_Sel,
  output logic              Out_Busy,
  output logic              Out_Done,
  output logic              Out_Timeout,
  output logic              Out_Overrun,
  output logic [15:0]       Out_Word_Cnt
`ifdef CHIP_HEADER_EN
  ,
  output logic [15:0]       Out_Header,
  output logic              Out_Header_En
`endif
);

  // Index needs one value beyond the last chip to signal end of scan
  localparam int                 IDX_W     = 5;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N_CHIP - 1);
  localparam logic [TMR_W-1:0]   START_LIM = TMR_W'(START_LEN);
  localparam logic [TMR_W-1:0]   TXTO_LIM  = TMR_W'(TX_TIMEOUT);
  localparam logic [TMR_W-1:0]   GAP_LIM   = TMR_W'(END_GAP);

  state_e                state_q;
  logic [N_CHIP-1:0]     mask_q;
  logic [11:0]           limit_q;
  logic [IDX_W-1:0]      idx_q;
  logic [N_CHIP-1:0]     startReadout_q;
  logic [3:0]            chipSel_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  timeout_q;
  logic                  overrun_q;
  logic [WORD_CNT_W-1:0] wordCnt_q;
  logic [WORD_CNT_W-1:0] wordCnt_d;
`ifdef CHIP_HEADER_EN
  logic [15:0]           header_q;
  logic                  headerEn_q;
`endif

  logic              maskHit;
  logic              scanEnd;
  logic              overrunHit;
  logic [N_CHIP-1:0] selOneHot;
  logic              tmrClear;
  logic              tmrCount;
  logic [TMR_W-1:0]  tmrLimit;
  logic              tmrExpire;

  // Decode the scan index into the mask bit under test and a one-hot strobe
  always_comb begin
    maskHit   = 1'b0;
    selOneHot = '0;
    for (int i = 0; i < N_CHIP; i++) begin
      if (idx_q == i[IDX_W-1:0]) begin
        maskHit      = mask_q[i];
        selOneHot[i] = 1'b1;
      end
    end
  end

  assign scanEnd = (idx_q > LAST_IDX);

  // Next word count and the over-limit test on the incremented value
  always_comb begin
    wordCnt_d  = wordCnt_q;
    overrunHit = 1'b0;
    if (In_Word_En) begin
      wordCnt_d  = satInc(wordCnt_q);
      overrunHit = (wordCnt_d > {{(WORD_CNT_W-12){1'b0}}, limit_q});
    end
  end

  // One shared timer serves the start pulse, the TX timeout and the end gap
  always_comb begin
    tmrClear = 1'b1;
    tmrCount = 1'b0;
    tmrLimit = START_LIM;
    case (state_q)
      START: begin
        tmrClear = 1'b0;
        tmrCount = 1'b1;
        tmrLimit = START_LIM;
      end
      WAIT_TX: begin
        tmrClear = !In_TransmitOnb;
        tmrCount = In_TransmitOnb;
        tmrLimit = TXTO_LIM;
      end
      RECEIVE: begin
        tmrClear = !In_TransmitOnb;
        tmrCount = In_TransmitOnb;
        tmrLimit = GAP_LIM;
      end
      default: ;
    endcase
  end

  readout_gap_timer #(
    .W(TMR_W)
  ) uTimer (
    .Clk      (Clk),
    .Rst_N    (Rst_N),
    .Clear_i  (tmrClear),
    .Count_i  (tmrCount),
    .Limit_i  (tmrLimit),
    .Expire_o (tmrExpire)
  );

  // Chain sequencing FSM with all status outputs registered
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q        <= IDLE;
      mask_q         <= '0;
      limit_q        <= '0;
      idx_q          <= '0;
      startReadout_q <= '0;
      chipSel_q      <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
      overrun_q      <= 1'b0;
      wordCnt_q      <= '0;
`ifdef CHIP_HEADER_EN
      header_q       <= '0;
      headerEn_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef CHIP_HEADER_EN
      headerEn_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (In_Start) begin
            mask_q    <= In_Chip_Mask;
            limit_q   <= In_Num_Receive;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b1;
            idx_q     <= '0;
            state_q   <= SCAN;
          end
        end
        SCAN: begin
          if (scanEnd) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else if (maskHit) begin
            chipSel_q      <= idx_q[3:0];
            wordCnt_q      <= '0;
            startReadout_q <= selOneHot;
            state_q        <= START;
`ifdef CHIP_HEADER_EN
            header_q       <= {HDR_TAG, 8'h00, idx_q[3:0]};
            headerEn_q     <= 1'b1;
`endif
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        START: begin
          if (tmrExpire) begin
            startReadout_q <= '0;
            state_q        <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          if (!In_TransmitOnb) begin
            state_q <= RECEIVE;
          end else if (tmrExpire) begin
            timeout_q <= 1'b1;
            state_q   <= NEXT;
          end
        end
        RECEIVE: begin
          wordCnt_q <= wordCnt_d;
          if (overrunHit) begin
            overrun_q <= 1'b1;
            state_q   <= NEXT;
          end else if (tmrExpire) begin
            state_q <= NEXT;
          end
        end
        NEXT: begin
          idx_q   <= idx_q + 1'b1;
          state_q <= SCAN;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Out_StartReadout = startReadout_q;
  assign Out_Chip_Sel     = chipSel_q;
  assign Out_Busy         = busy_q;
  assign Out_Done         = done_q;
  assign Out_Timeout      = timeout_q;
  assign Out_Overrun      = overrun_q;
  assign Out_Word_Cnt     = wordCnt_q;
`ifdef CHIP_HEADER_EN
  assign Out_Header       = header_q;
  assign Out_Header_En    = headerEn_q;
`endif

endmodule

// File: doc/readout_chain_ctrl.md
Name: readout_chain_ctrl

Overview:
Sequences serial readout of a daisy chain of front-end ASICs, one chip at a time, feeding the existing Dout/TransmitOnb deserializer.
- Per enabled chip: pulses that chip's StartReadout, waits for TransmitOnb to fall, counts deserialized words, detects end of transmission, then advances to the next chip.
- Sits between the acquisition-control FSM (start request) and the per-chip readout strobes; reports busy/done/error status to the DIF control logic.

Parameters:
N_CHIP, 4, number of chips in the chain (1..16)
START_LEN, 4, StartReadout pulse width in Clk cycles (>=1)
TX_TIMEOUT, 4096, max cycles to wait for TransmitOnb low after start (>=2)
END_GAP, 8, consecutive cycles TransmitOnb must be high to declare end of chip (>=1)

Ports:
Clk  in  1  40 MHz system clock
Rst_N  in  1  asynchronous, active-low reset
In_Start  in  1  single-cycle request to read the whole chain
In_Chip_Mask  in  N_CHIP  1 = chip enabled; sampled at accepted In_Start
In_TransmitOnb  in  1  chain transmit flag, low active, already synchronous to Clk
In_Word_En  in  1  one-cycle strobe per word from deserializer
In_Num_Receive  in  12  per-chip word limit; sampled at accepted In_Start
Out_StartReadout  out  N_CHIP  one-hot start pulse to selected chip
Out_Chip_Sel  out  4  index of chip being read
Out_Busy  out  1  high from accepted start until Done
Out_Done  out  1  one-cycle pulse at end of chain
Out_Timeout  out  1  sticky: some chip never asserted TransmitOn
Out_Overrun  out  1  sticky: some chip exceeded word limit
Out_Word_Cnt  out  16  words of current/last chip, saturating at 16'hFFFF

Behaviour:
- Reset values: all outputs 0; state IDLE; latched mask 0; limit 0.
- IDLE:
  - On In_Start, latch mask and limit, clear Timeout/Overrun, set Busy the next cycle, and go to SCAN.
  - In_Start while Busy is ignored.
- SCAN:
  - Searches from the current index upward for the next set mask bit, one index per cycle. Index starts at 0.
  - Found: set Out_Chip_Sel, clear Word_Cnt, go to START.
  - Index passes N_CHIP-1: go to DONE.
  - Mask all zero: Done pulses within N_CHIP+2 cycles of start.
- START:
  - Out_StartReadout[sel] = 1 for exactly START_LEN cycles; all other bits 0.
  - Then go to WAIT_TX with the timeout counter at 0.
- WAIT_TX:
  - In_TransmitOnb low: go to RECEIVE.
  - Counter reaches TX_TIMEOUT-1: set Out_Timeout, go to NEXT.
- RECEIVE:
  - Each In_Word_En increments Word_Cnt (saturating).
  - When Word_Cnt > limit, set Out_Overrun and go to NEXT immediately.
  - End detect: gap counter increments while TransmitOnb high and resets when it is low. When it reaches END_GAP, go to NEXT.
  - Word_En in the same cycle as end detect is still counted.
- NEXT: index+1, go to SCAN. Word_Cnt holds its value until the next chip is selected.
- DONE: Out_Done = 1 for one cycle, Busy drops the same cycle, go to IDLE.
- Reset mid-operation: immediate return to reset values, StartReadout forced low asynchronously.
- Latency: accepted start to first StartReadout rising edge = 2 + (cycles to find first enabled chip).

Optional Feature:
Macro CHIP_HEADER_EN.
- Defined: adds ports Out_Header (16) and Out_Header_En (1). On entry to START, emits one cycle with Out_Header_En = 1 and Out_Header = {4'hC, 8'h00, chip index}, for downstream packet framing.
- Undefined: ports absent, no header logic.

Decomposition:
- Shared package readout_pkg:
  - state encoding localparams IDLE/SCAN/START/WAIT_TX/RECEIVE/NEXT/DONE
  - header tag constant 4'hC
  - word-count width 16
- One sub-module, readout_gap_timer: generic load/count/expire counter, used for the start-pulse width, TX timeout and end gap.

Test Plan:
- Mask 4'b1111, each chip sends 10 words then TransmitOnb high → four StartReadout pulses, 4 cycles each, in order 0..3; Word_Cnt = 10 per chip; one Done; no flags.
- Mask 4'b0101 → pulses only on bits 0 and 2; Chip_Sel steps 0 then 2.
- Chip 1 never drops TransmitOnb → Out_Timeout = 1 after 4096 cycles; chain continues to chip 2; Done still pulses.
- In_Num_Receive = 5, chip sends 8 words → Overrun set at the 6th word; advances without waiting for end gap.
- Mask 0 → Done within 6 cycles, no StartReadout; then In_Start during Busy ignored; Rst_N low mid-RECEIVE → all outputs 0 asynchronously.
